// File: rtl/result_uart_streamer_if.sv
// Control, result-SRAM read port and UART status bundle for result_uart_streamer.
// The master modport is the streamer side; slave is the controller/memory/line side.
interface result_uart_streamer_if #(
  parameter int unsigned ADDR_W = 6
) ();
  logic              start;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic              uart_tx;
  logic              busy;
  logic              done;

  modport master (
    input  start, mem_rdata,
    output mem_rd_en, mem_addr, uart_tx, busy, done
  );

  modport slave (
    output start, mem_rdata,
    input  mem_rd_en, mem_addr, uart_tx, busy, done
  );
endinterface

// File: rtl/result_uart_streamer.sv
// Dumps the result SRAM as 8N1 UART frames: a sync header, then hi/lo bytes per word.
// Each word is prefetched during the preceding frame so frames run back-to-back.
module result_uart_streamer #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned ADDR_W       = 6,
  parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
  input logic                    clk,
  input logic                    reset,
  result_uart_streamer_if.master bus
);

  localparam int unsigned       BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StHdr, StHi, StLo} state_e;

  state_e            r_state, w_state_d;
  logic [BAUD_W-1:0] r_baud, w_baud_d;
  logic [3:0]        r_bit, w_bit_d;
  logic [7:0]        r_shift, w_shift_d;
  logic              r_tx, w_tx_d;
  logic              r_busy, w_busy_d;
  logic              r_done, w_done_d;
  logic              r_rd_en, w_rd_en_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic [ADDR_W-1:0] r_idx, w_idx_d;
  logic              r_rd_en_q;
  logic [15:0]       r_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_addr  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_d;
      r_baud  <= w_baud_d;
      r_bit   <= w_bit_d;
      r_shift <= w_shift_d;
      r_tx    <= w_tx_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_rd_en <= w_rd_en_d;
      r_addr  <= w_addr_d;
      r_idx   <= w_idx_d;
    end
  end

  // SRAM data is valid one cycle after the strobe; capture it then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_en_q <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_rd_en_q <= r_rd_en;
      if (r_rd_en_q) r_hold <= bus.mem_rdata;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_baud_d  = r_baud;
    w_bit_d   = r_bit;
    w_shift_d = r_shift;
    w_tx_d    = r_tx;
    w_busy_d  = r_busy;
    w_done_d  = 1'b0;
    w_rd_en_d = 1'b0;
    w_addr_d  = r_addr;
    w_idx_d   = r_idx;

    if (r_state == StIdle) begin
      if (bus.start) begin
        w_state_d = StHdr;
        w_busy_d  = 1'b1;
        w_tx_d    = 1'b0;
        w_baud_d  = '0;
        w_bit_d   = '0;
        w_shift_d = HDR_BYTE;
        w_rd_en_d = 1'b1;
        w_addr_d  = '0;
        w_idx_d   = '0;
      end
    end else if (r_baud != BAUD_LAST) begin
      w_baud_d = r_baud + 1'b1;
    end else begin
      w_baud_d = '0;
      if (r_bit != 4'd9) begin
        // Entering bit r_bit+1: data bits 1..8 are LSB first, bit 9 is the stop bit.
        w_bit_d = r_bit + 4'd1;
        w_tx_d  = (r_bit == 4'd8) ? 1'b1 : r_shift[r_bit[2:0]];
      end else begin
        w_bit_d = '0;
        w_tx_d  = 1'b0;
        unique case (r_state)
          StHdr: begin
            w_state_d = StHi;
            w_shift_d = r_hold[15:8];
          end
          StHi: begin
            w_state_d = StLo;
            w_shift_d = r_hold[7:0];
            if (r_idx != IDX_LAST) begin
              w_rd_en_d = 1'b1;
              w_addr_d  = r_idx + 1'b1;
            end
          end
          StLo: begin
            if (r_idx == IDX_LAST) begin
              w_state_d = StIdle;
              w_busy_d  = 1'b0;
              w_done_d  = 1'b1;
              w_tx_d    = 1'b1;
            end else begin
              w_state_d = StHi;
              w_idx_d   = r_idx + 1'b1;
              w_shift_d = r_hold[15:8];
            end
          end
          default: w_state_d = StIdle;
        endcase
      end
    end
  end

  assign bus.mem_rd_en = r_rd_en;
  assign bus.mem_addr  = r_addr;
  assign bus.uart_tx   = r_tx;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: doc/result_uart_streamer.md
# result_uart_streamer

Downstream stage of the convolution engine. After a convolution completes, it reads every word of the output result SRAM in address order and serialises the words onto the board UART TX line as 8N1 frames, preceded by a one-byte sync header. It owns `uart_tx` at the top level and is the only consumer of the result memory's read port.

## Interface

Parameters:

- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200 baud). Must be ≥ 2.
- `DEPTH`, default 64: number of result words to dump.
- `ADDR_W`, default 6: result SRAM address width. Must satisfy 2^ADDR_W ≥ DEPTH.
- `HDR_BYTE`, default 8'hA5: sync byte sent before the first word.

Ports:

- `clk`, in, 1: single clock; all logic is on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request a dump. Sampled only while idle.
- `mem_rd_en`, out, 1: one-cycle read strobe to the result SRAM.
- `mem_addr`, out, ADDR_W: result SRAM read address.
- `mem_rdata`, in, 16: result word, valid exactly one cycle after `mem_rd_en`.
- `uart_tx`, out, 1: serial line; idles high.
- `busy`, out, 1: high from the accept of `start` until the end of the final stop bit.
- `done`, out, 1: one-cycle pulse when the dump completes.

## Operation

- Reset values:
  - `uart_tx`=1, `busy`=0, `done`=0, `mem_rd_en`=0, `mem_addr`=0.
  - Word counter and bit/baud counters are 0.
  - Controller is in IDLE.
- Byte stream order:
  - `HDR_BYTE` first.
  - Then, for address 0 .. DEPTH-1: high byte `mem_rdata[15:8]`, then low byte `mem_rdata[7:0]`.
  - Total: 1 + 2·DEPTH bytes.
- Frame format:
  - Start bit (0), then 8 data bits LSB first, then stop bit (1).
  - Each bit is held exactly `CLKS_PER_BIT` cycles.
- Controller states:
  - IDLE → HDR on `start`.
  - HDR → HI when the header frame ends.
  - HI → LO when the high-byte frame ends.
  - LO → HI when the low-byte frame ends and the word index < DEPTH-1.
  - LO → IDLE (with `done`) when the low-byte frame ends and the word index = DEPTH-1.
- The TX bit engine is a separate counter pair: a baud counter 0..CLKS_PER_BIT-1 and a bit index 0..9.
- Prefetch:
  - The read of word k is issued (`mem_rd_en`=1, `mem_addr`=k) on the first cycle of the frame that precedes word k's high byte. That frame is the header for k=0, and word k-1's low byte otherwise.
  - `mem_rdata` is captured into a 16-bit hold register on the next cycle.
  - As a result, frames run back-to-back with no idle gap.
- `mem_addr` holds its last issued value between reads. It returns to 0 only on reset or on a new `start`.
- `start` while `busy`=1 is ignored. It is neither queued nor allowed to disturb the current frame.

## Timing

- Start latency: `start` sampled high at edge N in IDLE → `busy`=1 and `uart_tx`=0 (header start bit) from edge N+1.
- Header-frame read: `mem_rd_en` pulses for the single cycle after edge N+1, with `mem_addr`=0.
- Frame length: each frame is exactly 10·CLKS_PER_BIT cycles, and the next frame's start bit follows immediately.
- Dump duration: `uart_tx` is driven by the block for (1+2·DEPTH)·10·CLKS_PER_BIT cycles.
- Completion:
  - `done` pulses on the first cycle after the last stop bit.
  - `busy` falls on that same cycle.
  - `uart_tx` stays at 1.
- Start coincident with `done`: a `start` sampled high on the `done` cycle is accepted. The next header start bit begins on the following cycle.
- Reset mid-operation:
  - Asynchronous: `uart_tx` goes to 1 and `busy`/`done`/`mem_rd_en` go to 0 immediately, without waiting for a clock edge.
  - The partial frame is abandoned.
  - The next `start` restarts from the header and address 0.
- Address arithmetic: the word index counts 0..DEPTH-1 and never wraps mid-dump. Termination is by index compare, not by address overflow.

## Test plan

- Reset check: assert `reset` with no clock running → `uart_tx`=1, `busy`=0, `done`=0, `mem_rd_en`=0, `mem_addr`=0.
- Full dump content:
  - Setup: CLKS_PER_BIT=4, DEPTH=4, memory = {0x1234, 0xABCD, 0x0001, 0xFF00}; pulse `start`.
  - Required: decoded bytes A5 12 34 AB CD 00 01 FF 00; `done` exactly 360 cycles after the first start bit; exactly 4 `mem_rd_en` pulses at addresses 0..3.
- Bit timing: with the same setup, sample the header frame → every bit lasts 4 cycles, the data bits read LSB-first as 1,0,1,0,0,1,0,1, and the stop bit is 1.
- Busy-ignore: pulse `start` again mid-dump → byte stream and `done` timing are identical to the previous test, and no second dump follows.
- Reset mid-frame:
  - Stimulus: assert `reset` during the data bits of byte 0xAB.
  - Required: `uart_tx`=1 with no clock edge needed; after release and a new `start`, the stream restarts at A5 with address 0.
- Back-to-back dumps: assert `start` on the `done` cycle → the second header start bit appears on the next cycle, and the second stream is identical to the first.
